// File: rtl/mem_store_ctrl_pkg.sv
// Shared types and constants for the byte-serial store controller.
package mem_store_ctrl_pkg;

    typedef logic [31:0] ADDR_TP;
    typedef logic [31:0] WORD_TP;

    localparam logic [3:0] LEN_SB = 4'd0;
    localparam logic [3:0] LEN_SH = 4'd1;
    localparam logic [3:0] LEN_SW = 4'd3;

    localparam logic [1:0] IO_SEL_HI_DEF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } st_e;

    // Unsupported length codes fall back to a full word.
    function automatic logic [1:0] norm_len(input logic [3:0] len);
        logic [1:0] r;
        case (len)
            LEN_SB:  r = 2'd0;
            LEN_SH:  r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_store_ctrl.sv
// Store controller: serialises a SB/SH/SW store into byte writes on the
// shared RAM bus, stalling on bus grant and on a full I/O sink.
module mem_store_ctrl
    import mem_store_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_SEL_HI = IO_SEL_HI_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       st_ena,
    input  ADDR_TP     st_addr,
    input  WORD_TP     st_data,
    input  logic [3:0] st_len,
    output logic       st_done,
    output logic       bus_req,
    input  logic       bus_gnt,
    input  logic       io_buffer_full,
    output ADDR_TP     ram_a,
    output logic [7:0] ram_dout,
    output logic       ram_wr
);

    st_e        state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    ADDR_TP     addr_q, addr_d;
    WORD_TP     data_q, data_d;
    logic [1:0] len_q, len_d;
    ADDR_TP     ram_a_q, ram_a_d;
    logic [7:0] ram_dout_q, ram_dout_d;
    logic       ram_wr_q, ram_wr_d;
    logic       st_done_q, st_done_d;

    logic       io_stall;
    logic [7:0] byte_sel;

    assign io_stall = (addr_q[17:16] == IO_SEL_HI) && io_buffer_full;

    always_comb begin
        byte_sel = data_q[7:0];
        unique case (cnt_q)
            2'd0: byte_sel = data_q[7:0];
            2'd1: byte_sel = data_q[15:8];
            2'd2: byte_sel = data_q[23:16];
            2'd3: byte_sel = data_q[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        len_d      = len_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = 1'b0;
        st_done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (st_ena) begin
                    addr_d  = st_addr;
                    data_d  = st_data;
                    len_d   = norm_len(st_len);
                    cnt_d   = 2'd0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus_gnt && !io_stall) begin
                    ram_a_d    = addr_q + ADDR_TP'(cnt_q);
                    ram_dout_d = byte_sel;
                    ram_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == len_q) begin
                        st_done_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            len_q      <= 2'd0;
            ram_a_q    <= '0;
            ram_dout_q <= 8'd0;
            ram_wr_q   <= 1'b0;
            st_done_q  <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            len_q      <= len_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            st_done_q  <= st_done_d;
        end else begin
            // Frozen: pulses already shown must not reappear on resume.
            ram_wr_q  <= 1'b0;
            st_done_q <= 1'b0;
        end
    end

    assign bus_req  = (state_q == ST_WRITE);
    assign ram_a    = ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q & rdy;
    assign st_done  = st_done_q & rdy;

endmodule

// File: doc/mem_store_ctrl.md
MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

Interface
REQ-001 Parameter IO_SEL_HI, default 2'b11: value of addr[17:16] that marks the I/O-mapped region.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rdy  in  1  global ready; low freezes all state and registered outputs.
REQ-005 st_ena  in  1  store request from the commit stage; held high until st_done is seen.
REQ-006 st_addr  in  32  byte address of the store.
REQ-007 st_data  in  32  store data, little-endian.
REQ-008 st_len  in  4  byte count minus 1: 0=SB, 1=SH, 3=SW.
REQ-009 st_done  out  1  one-cycle completion pulse to the commit stage.
REQ-010 bus_req  out  1  RAM bus request to the memctrl arbiter.
REQ-011 bus_gnt  in  1  RAM bus grant for the current cycle.
REQ-012 io_buffer_full  in  1  I/O sink cannot accept a byte.
REQ-013 ram_a  out  32  RAM byte address.
REQ-014 ram_dout  out  8  RAM write byte.
REQ-015 ram_wr  out  1  RAM write strobe; 1 = write this cycle.

Function
REQ-016 The FSM SHALL have three states: IDLE, WRITE, DONE.
REQ-017 IDLE: when st_ena=1 at an edge, the block SHALL latch addr, data and len, clear the byte counter cnt, and enter WRITE.
REQ-018 WRITE SHALL hold bus_req=1.
REQ-019 WRITE, per edge with bus_gnt=1 and no I/O stall: register ram_a=addr+cnt, ram_dout=data[8*cnt+7:8*cnt], ram_wr=1; then cnt+1.
REQ-020 An I/O stall SHALL mean addr[17:16]==IO_SEL_HI and io_buffer_full=1; on a stall or bus_gnt=0, ram_wr SHALL be 0 that cycle and cnt SHALL hold.
REQ-021 The edge issuing byte cnt==len SHALL also register st_done=1 and enter DONE.
REQ-022 DONE SHALL last exactly one cycle, return to IDLE unconditionally, and ignore st_ena (the requester updates st_ena/st_addr on the edge it sees st_done).
REQ-023 Back-to-back stores SHALL be supported: st_ena held high with new st_addr after DONE SHALL be accepted at the first IDLE edge.
REQ-024 ram_wr and st_done SHALL be 0 in every cycle not named in REQ-019/REQ-021; ram_a and ram_dout SHALL hold their last value.
REQ-025 Address arithmetic SHALL be 32-bit modulo 2^32.
REQ-026 st_len values other than 0/1/3 SHALL be treated as 3.
REQ-027 Minimum latency from acceptance to st_done SHALL be len+1 cycles.
REQ-028 Latched addr/data/len SHALL be unaffected by changes on st_* inputs while in WRITE.
REQ-029 rdy=0 SHALL suppress all updates except that ram_wr and st_done SHALL read 0.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, cnt=0, st_done=0, bus_req=0, ram_wr=0, ram_a=0, ram_dout=0, latched fields=0.
REQ-031 Reset mid-WRITE SHALL abort the store with no further writes and no st_done.

Structure
REQ-032 ADDR_TP, WORD_TP, the SB/SH/SW length codes and the IO_SEL_HI value SHALL live in the shared utils header.
REQ-033 No sub-module is required; the byte-lane mux SHALL be inline.

Verification
REQ-034 SW: addr 0x100, data 0xDEADBEEF, bus_gnt=1 -> writes 0x100:EF, 0x101:BE, 0x102:AD, 0x103:DE on four consecutive cycles; st_done pulses with the last write.
REQ-035 SB to 0x30000 with io_buffer_full=1 for 3 cycles, then 0 -> no ram_wr while full; a single write of data[7:0] to 0x30000 follows; one st_done.
REQ-036 SH at 0x200 with bus_gnt toggling 1,0,1 -> writes to 0x200 then 0x201, separated by one idle cycle; cnt holds during the idle cycle.
REQ-037 Back-to-back SW then SB with st_ena never dropping -> second store accepted the cycle after DONE; exactly two st_done pulses.
REQ-038 rst_n=0 after the 2nd byte of an SW -> all outputs 0 at once, no st_done; the next request after reset completes normally.
REQ-039 SW at 0xFFFFFFFE -> writes go to FFFFFFFE, FFFFFFFF, 00000000, 00000001.
